// File: rtl/ahbl_axi_wrpack_fifo_if.sv
// Bus bundle for the narrow-write / wide-read packing FIFO.
// The slave modport is the FIFO side; the master modport is the side that drives it.
interface ahbl_axi_wrpack_fifo_if #(
  parameter int NARROW_DWIDTH = 32,
  parameter int WIDE_DWIDTH   = 64,
  parameter int AWIDTH        = 4
);
  logic                       flush;
  logic                       wr_en;
  logic [NARROW_DWIDTH-1:0]   wr_data;
  logic                       wr_last;
  logic                       wr_ready;
  logic                       wr_drop;
  logic                       rd_en;
  logic [WIDE_DWIDTH-1:0]     rd_data;
  logic [WIDE_DWIDTH/8-1:0]   rd_strb;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       fifo_afull;
  logic [AWIDTH:0]            level;

  modport slave (
    input  flush, wr_en, wr_data, wr_last, rd_en,
    output wr_ready, wr_drop, rd_data, rd_strb, fifo_empty, fifo_full, fifo_afull, level
  );

  modport master (
    output flush, wr_en, wr_data, wr_last, rd_en,
    input  wr_ready, wr_drop, rd_data, rd_strb, fifo_empty, fifo_full, fifo_afull, level
  );
endinterface

// File: rtl/ahbl_axi_wrpack_fifo.sv
// Single-clock FIFO packing narrow write beats into wide words with byte strobes,
// first-word-fall-through read side, registered level/empty/full/almost-full.
module ahbl_axi_wrpack_fifo #(
  parameter int NARROW_DWIDTH = 32,
  parameter int WIDE_DWIDTH   = 64,
  parameter int AWIDTH        = 4,
  parameter int AFULL_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ahbl_axi_wrpack_fifo_if.slave bus
);
  localparam int R     = WIDE_DWIDTH / NARROW_DWIDTH;
  localparam int NB    = NARROW_DWIDTH / 8;
  localparam int SW    = WIDE_DWIDTH / 8;
  localparam int DEPTH = 1 << AWIDTH;
  localparam int LW    = (R > 1) ? $clog2(R) : 1;

  logic [LW-1:0]          r_lane;
  logic [WIDE_DWIDTH-1:0] r_hold;
  logic [R-1:0]           r_mask;
  logic [AWIDTH:0]        r_wptr, r_rptr, r_level;
  logic                   r_empty, r_full, r_afull, r_drop;
  logic [WIDE_DWIDTH-1:0] r_mem_d [DEPTH];
  logic [SW-1:0]          r_mem_s [DEPTH];

  logic                   w_accept, w_pop, w_commit;
  logic [WIDE_DWIDTH-1:0] w_word;
  logic [R-1:0]           w_mask;
  logic [SW-1:0]          w_strb;
  logic [AWIDTH:0]        w_wptr_nxt, w_rptr_nxt, w_level_nxt;

  always_comb begin
    w_accept = bus.wr_en & ~r_full & ~bus.flush;
    w_pop    = bus.rd_en & ~r_empty & ~bus.flush;
    w_word   = r_hold;
    w_mask   = r_mask;
    for (int unsigned k = 0; k < R; k++) begin
      if (r_lane == LW'(k)) begin
        w_word[k*NARROW_DWIDTH +: NARROW_DWIDTH] = bus.wr_data;
        w_mask[k] = 1'b1;
      end
    end
    w_strb = '0;
    for (int unsigned k = 0; k < R; k++) begin
      w_strb[k*NB +: NB] = {NB{w_mask[k]}};
    end
    w_commit    = w_accept & (bus.wr_last | (r_lane == LW'(R - 1)));
    w_wptr_nxt  = r_wptr + (AWIDTH+1)'(w_commit);
    w_rptr_nxt  = r_rptr + (AWIDTH+1)'(w_pop);
    w_level_nxt = w_wptr_nxt - w_rptr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane  <= '0;
      r_hold  <= '0;
      r_mask  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_drop  <= 1'b0;
    end else if (bus.flush) begin
      r_lane  <= '0;
      r_hold  <= '0;
      r_mask  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      // Any beat offered while full is refused, so the packer never strands data.
      r_drop <= bus.wr_en & r_full;
      if (w_accept) begin
        if (w_commit) begin
          r_lane <= '0;
          r_hold <= '0;
          r_mask <= '0;
        end else begin
          r_lane <= r_lane + LW'(1);
          r_hold <= w_word;
          r_mask <= w_mask;
        end
      end
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == (AWIDTH+1)'(DEPTH));
      r_afull <= (w_level_nxt >= (AWIDTH+1)'(AFULL_THRESH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem_d[r_wptr[AWIDTH-1:0]] <= w_word;
      r_mem_s[r_wptr[AWIDTH-1:0]] <= w_strb;
    end
  end

  assign bus.wr_ready   = ~r_full;
  assign bus.wr_drop    = r_drop;
  assign bus.fifo_empty = r_empty;
  assign bus.fifo_full  = r_full;
  assign bus.fifo_afull = r_afull;
  assign bus.level      = r_level;
  assign bus.rd_data    = r_empty ? '0 : r_mem_d[r_rptr[AWIDTH-1:0]];
  assign bus.rd_strb    = r_empty ? '0 : r_mem_s[r_rptr[AWIDTH-1:0]];
endmodule

// File: tb/tb_ahbl_axi_wrpack_fifo.sv
// Self-checking bench: default 32/64 instance against a queue-based model,
// plus directed checks on 32/32 and 32/128 instances.
module tb_ahbl_axi_wrpack_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahbl_axi_wrpack_fifo_if #(.NARROW_DWIDTH(32), .WIDE_DWIDTH(64),  .AWIDTH(4)) b0();
  ahbl_axi_wrpack_fifo_if #(.NARROW_DWIDTH(32), .WIDE_DWIDTH(32),  .AWIDTH(4)) b1();
  ahbl_axi_wrpack_fifo_if #(.NARROW_DWIDTH(32), .WIDE_DWIDTH(128), .AWIDTH(4)) b2();

  ahbl_axi_wrpack_fifo #(.NARROW_DWIDTH(32), .WIDE_DWIDTH(64), .AWIDTH(4), .AFULL_THRESH(12))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  ahbl_axi_wrpack_fifo #(.NARROW_DWIDTH(32), .WIDE_DWIDTH(32), .AWIDTH(4), .AFULL_THRESH(12))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ahbl_axi_wrpack_fifo #(.NARROW_DWIDTH(32), .WIDE_DWIDTH(128), .AWIDTH(4), .AFULL_THRESH(12))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int ntot = 0;
  int npass = 0;
  int nfail = 0;

  // Model of the 32/64 instance: committed words, pending beats, drop flag.
  logic [63:0] mq_d [$];
  logic [7:0]  mq_s [$];
  logic [31:0] pend [$];
  logic        m_drop = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq_d.delete();
    mq_s.delete();
    pend.delete();
    m_drop = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = mq_d.size();
    chk("level",    b0.level, n);
    chk("empty",    b0.fifo_empty, n == 0);
    chk("full",     b0.fifo_full, n == 16);
    chk("afull",    b0.fifo_afull, n >= 12);
    chk("wr_ready", b0.wr_ready, n != 16);
    chk("wr_drop",  b0.wr_drop, m_drop);
    chk("rd_data",  b0.rd_data, (n == 0) ? 64'h0 : mq_d[0]);
    chk("rd_strb",  b0.rd_strb, (n == 0) ? 8'h0 : mq_s[0]);
  endtask

  task automatic step(input logic we, input logic [31:0] d, input logic wl,
                      input logic re, input logic fl);
    logic        full, do_pop, acc;
    logic [63:0] word;
    logic [7:0]  strb;
    b0.flush = fl; b0.wr_en = we; b0.wr_data = d; b0.wr_last = wl; b0.rd_en = re;
    if (fl) model_clear();
    else begin
      full   = (mq_d.size() == 16);
      m_drop = we && full;
      do_pop = re && (mq_d.size() != 0);
      acc    = we && !full;
      if (do_pop) begin
        void'(mq_d.pop_front());
        void'(mq_s.pop_front());
      end
      if (acc) begin
        pend.push_back(d);
        if (wl || pend.size() == 2) begin
          word = '0;
          strb = '0;
          for (int k = 0; k < pend.size(); k++) begin
            word[k*32 +: 32] = pend[k];
            strb[k*4 +: 4]   = 4'hF;
          end
          mq_d.push_back(word);
          mq_s.push_back(strb);
          pend.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle0();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a, b, c, d;
    b0.flush = 0; b0.wr_en = 0; b0.wr_data = 0; b0.wr_last = 0; b0.rd_en = 0;
    b1.flush = 0; b1.wr_en = 0; b1.wr_data = 0; b1.wr_last = 0; b1.rd_en = 0;
    b2.flush = 0; b2.wr_en = 0; b2.wr_data = 0; b2.wr_last = 0; b2.rd_en = 0;
    #12;
    check_all();
    rst_n = 1'b1;

    // Two beats pack into one word.
    step(1, 32'h11111111, 0, 0, 0);
    step(1, 32'h22222222, 0, 0, 0);
    chk("tp1_data", b0.rd_data, 64'h22222222_11111111);
    chk("tp1_strb", b0.rd_strb, 8'hFF);
    step(0, 0, 0, 1, 0);

    // Partial close, then a fresh pair from lane 0.
    step(1, 32'hAAAA5555, 1, 0, 0);
    chk("tp2_data", b0.rd_data, 64'h00000000_AAAA5555);
    chk("tp2_strb", b0.rd_strb, 8'h0F);
    step(0, 0, 0, 1, 0);
    step(1, 32'h33333333, 0, 0, 0);
    step(1, 32'h44444444, 0, 0, 0);
    chk("tp2_pair", b0.rd_data, 64'h44444444_33333333);
    step(0, 0, 0, 1, 0);

    // Fill to full, overflow, then full with simultaneous pop and write.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) step(1, $urandom(), 0, 0, 0);
    chk("fill_full", b0.fifo_full, 1'b1);
    chk("fill_lvl",  b0.level, 5'd16);
    step(1, $urandom(), 0, 0, 0);
    chk("ovf_drop", b0.wr_drop, 1'b1);
    idle0();
    step(1, $urandom(), 1, 1, 0);
    chk("fullrw_drop", b0.wr_drop, 1'b1);
    chk("fullrw_lvl",  b0.level, 5'd15);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);

    // Continuous stream with reads from word 3 onward, across pointer wrap.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 80; i++) step(1, $urandom(), 0, i >= 4, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

    // Pop coincident with commit at level 5.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, $urandom(), 0, 0, 0);
    step(1, $urandom(), 0, 0, 0);
    step(1, $urandom(), 0, 1, 0);
    chk("coinc_lvl", b0.level, 5'd5);

    // Flush with a pending lane and a beat on the flush cycle.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(1, $urandom(), 0, 0, 0);
    chk("pre_flush_lvl", b0.level, 5'd7);
    step(1, $urandom(), 0, 0, 1);
    chk("flush_empty", b0.fifo_empty, 1'b1);
    chk("flush_lvl",   b0.level, 5'd0);
    a = $urandom(); b = $urandom();
    step(1, a, 0, 0, 0);
    step(1, b, 0, 0, 0);
    chk("flush_fresh", b0.rd_data, {b, a});
    chk("flush_strb",  b0.rd_strb, 8'hFF);

    // Random traffic including occasional flushes.
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, $urandom(), $urandom_range(3) == 0,
           $urandom_range(2) == 0, $urandom_range(63) == 0);
    step(0, 0, 0, 0, 1);

    // 32/32: every beat commits with full strobes.
    for (int i = 0; i < 4; i++) begin
      a = $urandom();
      b1.wr_en = 1; b1.wr_data = a; b1.wr_last = i[0];
      @(posedge clk); #1;
      b1.wr_en = 0;
      chk("r1_data", b1.rd_data, a);
      chk("r1_strb", b1.rd_strb, 4'hF);
      chk("r1_lvl",  b1.level, 5'd1);
      b1.rd_en = 1;
      @(posedge clk); #1;
      b1.rd_en = 0;
      chk("r1_empty", b1.fifo_empty, 1'b1);
    end

    // 32/128: partial close after three beats, then a full word.
    a = $urandom(); b = $urandom(); c = $urandom(); d = $urandom();
    b2.wr_en = 1; b2.wr_last = 0;
    b2.wr_data = a; @(posedge clk); #1;
    b2.wr_data = b; @(posedge clk); #1;
    chk("r4_noword", b2.fifo_empty, 1'b1);
    b2.wr_data = c; b2.wr_last = 1; @(posedge clk); #1;
    b2.wr_en = 0; b2.wr_last = 0;
    chk("r4_pdata", b2.rd_data, {32'h0, c, b, a});
    chk("r4_pstrb", b2.rd_strb, 16'h0FFF);
    b2.rd_en = 1; @(posedge clk); #1; b2.rd_en = 0;
    b2.wr_en = 1;
    b2.wr_data = d; @(posedge clk); #1;
    b2.wr_data = c; @(posedge clk); #1;
    b2.wr_data = b; @(posedge clk); #1;
    b2.wr_data = a; @(posedge clk); #1;
    b2.wr_en = 0;
    chk("r4_fdata", b2.rd_data, {a, b, c, d});
    chk("r4_fstrb", b2.rd_strb, 16'hFFFF);

    // Asynchronous reset in the middle of packing.
    for (int i = 0; i < 6; i++) step(1, $urandom(), 0, 0, 0);
    step(1, 32'hDEADBEEF, 0, 0, 0);
    idle0();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    chk("rst_r4_empty", b2.fifo_empty, 1'b1);
    chk("rst_r4_data",  b2.rd_data, 128'h0);
    #2;
    rst_n = 1'b1;
    a = $urandom();
    step(1, a, 1, 0, 0);
    chk("post_rst_data", b0.rd_data, {32'h0, a});
    chk("post_rst_strb", b0.rd_strb, 8'h0F);
    step(0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
